dvd_motion_ctrl: RTL

Frame-synchronous motion scheduler for the one-pixel bouncing-logo display. It watches the sync generator's vsync output and turns it into clean one-cycle frame ticks. It then decides on which frames the logo moves, applies the bounce rules against the configured bounds, and exposes the current cell position, direction, bounce/corner events and a colour index to the pixel-compare datapath. It replaces ad-hoc per-design edge detection with one controller that also supports speed selection, pause and single-step.

---
 rtl/dvd_motion_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dvd_motion_ctrl.sv
// dvd_motion_ctrl
// Frame-synchronous motion scheduler for the one-pixel bouncing logo.
// It turns the vsync level into one-cycle frame ticks and decides which
// frames move the logo, honouring the speed, pause and single-step controls.
// It then applies the bounce rules against X_MAX/Y_MAX and reports
// bounce/corner events, a colour index and a corner-hit count.
//
// Ports:
//   clk         system/pixel clock
//   rst_n       synchronous, active-low reset
//   vsync       vertical sync level (same clock domain)
//   dir_init    {x,y} initial directions, sampled while rst_n=0 (1 = increasing)
//   speed       frames per step minus one
//   pause       suppress automatic moves
//   step_req    one-cycle request for a single move while paused
//   pos_x/pos_y current logo cell
//   dir_x/dir_y current direction per axis
//   frame_tick  one-cycle pulse per vsync rising edge
//   bounce      one-cycle pulse: at least one axis reversed on this move
//   corner      one-cycle pulse: both axes reversed on the same move
//   color_idx   colour selector, advances once per bouncing move
//   corner_cnt  corner hit counter, wraps
module dvd_motion_ctrl #(
  parameter int X_W    = 5,
  parameter int Y_W    = 4,
  parameter int X_MAX  = 19,
  parameter int Y_MAX  = 14,
  parameter int Y_INIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vsync,
  input  logic [1:0]     dir_init,
  input  logic [1:0]     speed,
  input  logic           pause,
  input  logic           step_req,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           dir_x,
  output logic           dir_y,
  output logic           frame_tick,
  output logic           bounce,
  output logic           corner,
  output logic [2:0]     color_idx,
  output logic [7:0]     corner_cnt
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] Y_START = Y_W'(Y_INIT);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           vsync_q;
  logic [1:0]     fcnt;
  logic [1:0]     fcnt_next;
  logic           move;
  logic           rev_x;
  logic           rev_y;
  logic [X_W-1:0] pos_x_next;
  logic [Y_W-1:0] pos_y_next;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state, frame-count update and move decision. A move only ever
  // happens on a frame tick; pause wins over a pending step, and any return
  // to RUN restarts the frame count so scheduling resumes cleanly.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    move       = 1'b0;
    case (state)
      RUN: begin
        if (pause) begin
          state_next = HOLD;
        end else if (frame_tick) begin
          if (fcnt >= speed) begin
            move      = 1'b1;
            fcnt_next = 2'd0;
          end else begin
            fcnt_next = fcnt + 2'd1;
          end
        end
      end
      HOLD: begin
        if (!pause) begin
          state_next = RUN;
          fcnt_next  = 2'd0;
        end else if (step_req) begin
          state_next = STEP;
        end
      end
      STEP: begin
        if (!pause) begin
          state_next = RUN;
          fcnt_next  = 2'd0;
        end else if (frame_tick) begin
          move       = 1'b1;
          state_next = HOLD;
        end
      end
      default: begin
        state_next = RUN;
        fcnt_next  = 2'd0;
      end
    endcase
  end

  // Per-axis bounce rule: hitting a wall reverses direction and spends the
  // step, so the position never leaves [0, MAX].
  always_comb begin
    rev_x = dir_x ? (pos_x == X_LAST) : (pos_x == '0);
    rev_y = dir_y ? (pos_y == Y_LAST) : (pos_y == '0);

    pos_x_next = pos_x;
    if (!rev_x) begin
      pos_x_next = dir_x ? (pos_x + X_ONE) : (pos_x - X_ONE);
    end

    pos_y_next = pos_y;
    if (!rev_y) begin
      pos_y_next = dir_y ? (pos_y + Y_ONE) : (pos_y - Y_ONE);
    end
  end

  // Edge detect and motion datapath. vsync_q resets high so a vsync that is
  // already asserted at reset release does not produce a spurious tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      fcnt       <= 2'd0;
      pos_x      <= '0;
      pos_y      <= Y_START;
      dir_x      <= dir_init[1];
      dir_y      <= dir_init[0];
      bounce     <= 1'b0;
      corner     <= 1'b0;
      color_idx  <= 3'd0;
      corner_cnt <= 8'd0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync & ~vsync_q;
      fcnt       <= fcnt_next;
      bounce     <= move & (rev_x | rev_y);
      corner     <= move & rev_x & rev_y;
      if (move) begin
        pos_x <= pos_x_next;
        pos_y <= pos_y_next;
        dir_x <= dir_x ^ rev_x;
        dir_y <= dir_y ^ rev_y;
        if (rev_x | rev_y) begin
          color_idx <= color_idx + 3'd1;
        end
        if (rev_x & rev_y) begin
          corner_cnt <= corner_cnt + 8'd1;
        end
      end
    end
  end

endmodule
